// File: rtl/obj_pkg.sv
// obj_pkg: shared sizes, sync-window defaults and the rectangle entry type
package obj_pkg;
  localparam int NUM_OBJ = 10;
  localparam int COORD_W = 10;
  localparam int COLOR_W = 8;
  localparam int VBP_DEF = 31;
  localparam int VFP_DEF = 511;
  typedef struct packed {
    logic [COORD_W-1:0] minx;
    logic [COORD_W-1:0] miny;
    logic [COORD_W-1:0] maxx;
    logic [COORD_W-1:0] maxy;
    logic [COLOR_W-1:0] color;
  } objEntry_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the last-granted pointer starts at B so A wins the first tie
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       block,
  output logic [1:0] grant
);
  logic lastB;
  always_comb grant = block ? 2'b00 : (req == 2'b11) ? (lastB ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lastB <= 1'b1;
    else if (|grant) lastB <= grant[1];
endmodule

// File: rtl/obj_table_ctrl.sv
// obj_table_ctrl: double-buffered rectangle table; writes land in a shadow copy that is
// published to the active copy on the vblank rising edge, only when something changed
module obj_table_ctrl #(
  parameter int NUM_OBJ = obj_pkg::NUM_OBJ,
  parameter int VBP = obj_pkg::VBP_DEF,
  parameter int VFP = obj_pkg::VFP_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               vc,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [3:0]               a_idx,
  input  logic [9:0]               a_minx,
  input  logic [9:0]               a_miny,
  input  logic [9:0]               a_maxx,
  input  logic [9:0]               a_maxy,
  input  logic [7:0]               a_color,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [3:0]               b_idx,
  input  logic [9:0]               b_minx,
  input  logic [9:0]               b_miny,
  input  logic [9:0]               b_maxx,
  input  logic [9:0]               b_maxy,
  input  logic [7:0]               b_color,
  output logic [NUM_OBJ-1:0][9:0]  minX,
  output logic [NUM_OBJ-1:0][9:0]  minY,
  output logic [NUM_OBJ-1:0][9:0]  maxX,
  output logic [NUM_OBJ-1:0][9:0]  maxY,
  output logic [NUM_OBJ-1:0][7:0]  color,
  output logic [15:0]              frame_cnt,
  output logic                     idx_err
);
  import obj_pkg::*;
  objEntry_t shadow [NUM_OBJ];
  objEntry_t active [NUM_OBJ];
  objEntry_t wEntry;
  logic [1:0] grant;
  logic [3:0] wIdx;
  logic vblank, vblankQ, commit, dirty, wr, inRange;
  assign vblank = int'(vc) >= VFP || int'(vc) < VBP;
  assign commit = vblank && !vblankQ;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({b_valid, a_valid}),
    .block (commit),
    .grant (grant)
  );
  assign a_ready = grant[0];
  assign b_ready = grant[1];
  always_comb begin
    wEntry  = grant[1] ? {b_minx, b_miny, b_maxx, b_maxy, b_color}
                       : {a_minx, a_miny, a_maxx, a_maxy, a_color};
    wIdx    = grant[1] ? b_idx : a_idx;
    wr      = |grant;
    inRange = int'(wIdx) < NUM_OBJ;
  end
  // Readies are low on the commit cycle, so a write and a publish never share an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow    <= '{default: '0};
      active    <= '{default: '0};
      dirty     <= 1'b0;
      vblankQ   <= 1'b1;
      frame_cnt <= '0;
      idx_err   <= 1'b0;
    end else begin
      vblankQ <= vblank;
      idx_err <= wr && !inRange;
      if (wr && inRange) begin
        shadow[wIdx] <= wEntry;
        dirty        <= 1'b1;
      end
      if (commit) begin
        dirty <= 1'b0;
        if (dirty) begin
          active    <= shadow;
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_out
    assign minX[i]  = active[i].minx;
    assign minY[i]  = active[i].miny;
    assign maxX[i]  = active[i].maxx;
    assign maxY[i]  = active[i].maxy;
    assign color[i] = active[i].color;
  end
endmodule

// File: tb/tb_obj_table_ctrl.sv
// tb_obj_table_ctrl: directed scenarios for the double-buffered object table
module tb_obj_table_ctrl;
  localparam int N = 10;
  logic clk = 1'b0, rst_n;
  logic [9:0] vc;
  logic a_valid, a_ready, b_valid, b_ready;
  logic [3:0] a_idx, b_idx;
  logic [9:0] a_minx, a_miny, a_maxx, a_maxy, b_minx, b_miny, b_maxx, b_maxy;
  logic [7:0] a_color, b_color;
  logic [N-1:0][9:0] minX, minY, maxX, maxY;
  logic [N-1:0][7:0] color;
  logic [15:0] frame_cnt;
  logic idx_err;
  logic [N-1:0][7:0] expCol;
  int compared = 0, mismatched = 0, curVc = 0;

  obj_table_ctrl #(.NUM_OBJ(N), .VBP(31), .VFP(511)) dut (
    .clk(clk), .rst_n(rst_n), .vc(vc),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_minx(a_minx), .a_miny(a_miny),
    .a_maxx(a_maxx), .a_maxy(a_maxy), .a_color(a_color),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_minx(b_minx), .b_miny(b_miny),
    .b_maxx(b_maxx), .b_maxy(b_maxy), .b_color(b_color),
    .minX(minX), .minY(minY), .maxX(maxX), .maxY(maxY), .color(color),
    .frame_cnt(frame_cnt), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic runTo(input int target);
    do begin
      curVc = (curVc == 524) ? 0 : curVc + 1;
      vc = 10'(curVc);
      cyc();
    end while (curVc != target);
  endtask

  task automatic setA(input int idx, input int x0, input int y0, input int x1, input int y1, input int c);
    a_idx = 4'(idx); a_minx = 10'(x0); a_miny = 10'(y0); a_maxx = 10'(x1); a_maxy = 10'(y1); a_color = 8'(c);
  endtask

  task automatic setB(input int idx, input int x0, input int y0, input int x1, input int y1, input int c);
    b_idx = 4'(idx); b_minx = 10'(x0); b_miny = 10'(y0); b_maxx = 10'(x1); b_maxy = 10'(y1); b_color = 8'(c);
  endtask

  task automatic doReset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; vc = '0; curVc = 0;
    setA(0, 0, 0, 0, 0, 0); setB(0, 0, 0, 0, 0, 0);
    #2;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vc = '0; curVc = 0; b_valid = 1'b0;
    a_valid = 1'b1; setA(1, 9, 9, 9, 9, 8'hFF); setB(0, 0, 0, 0, 0, 0);
    #2;
    cyc();
    compared++; if (frame_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    compared++; if (idx_err !== 1'b0) begin mismatched++; $display("FAIL reset_idx_err got %b want 0", idx_err); end
    compared++; if (minX !== '0 || maxY !== '0) begin mismatched++; $display("FAIL reset_bounds got minX=%h maxY=%h want 0", minX, maxY); end
    compared++; if (color !== '0) begin mismatched++; $display("FAIL reset_color got %h want 0", color); end
    compared++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    a_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_idle_sweep();
    for (int k = 0; k < 1050; k++) begin vc = 10'(k % 525); cyc(); end
    curVc = 524;
    compared++; if (frame_cnt !== 16'd0) begin mismatched++; $display("FAIL idle_frame_cnt got %0d want 0", frame_cnt); end
    compared++; if (minX !== '0 || minY !== '0 || maxX !== '0 || maxY !== '0 || color !== '0) begin mismatched++; $display("FAIL idle_table got nonzero color=%h want 0", color); end
  endtask

  task automatic test_single_write();
    runTo(199);
    curVc = 200; vc = 10'd200;
    a_valid = 1'b1; setA(3, 100, 50, 150, 120, 8'hE0);
    #1;
    compared++; if (a_ready !== 1'b1) begin mismatched++; $display("FAIL single_ready got %b want 1", a_ready); end
    cyc();
    a_valid = 1'b0;
    compared++; if (idx_err !== 1'b0) begin mismatched++; $display("FAIL single_idx_err got %b want 0", idx_err); end
    runTo(510);
    compared++; if (color[3] !== 8'h00 || minX[3] !== 10'd0 || frame_cnt !== 16'd0) begin mismatched++; $display("FAIL single_early got color=%h minX=%0d cnt=%0d want 0/0/0", color[3], minX[3], frame_cnt); end
    runTo(511);
    compared++; if (minX[3] !== 10'd100 || minY[3] !== 10'd50 || maxX[3] !== 10'd150 || maxY[3] !== 10'd120) begin mismatched++; $display("FAIL single_bounds got %0d,%0d,%0d,%0d want 100,50,150,120", minX[3], minY[3], maxX[3], maxY[3]); end
    compared++; if (color[3] !== 8'hE0 || frame_cnt !== 16'd1) begin mismatched++; $display("FAIL single_commit got color=%h cnt=%0d want e0/1", color[3], frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int na = 0, nb = 0;
    doReset();
    runTo(300);
    for (int c = 0; c < 8; c++) begin
      a_valid = na < 4; b_valid = nb < 4;
      setA(na, na, 0, 0, 0, 8'h10 + na); setB(4 + nb, 0, nb, 0, 0, 8'h20 + nb);
      #1;
      compared++; if (a_ready && b_ready) begin mismatched++; $display("FAIL b2b_both_ready cycle %0d got a=1 b=1 want one", c); end
      compared++; if (a_ready !== (c % 2 == 0) || b_ready !== (c % 2 == 1)) begin mismatched++; $display("FAIL b2b_grant cycle %0d got a=%b b=%b want a=%b", c, a_ready, b_ready, c % 2 == 0); end
      if (a_ready) na++;
      if (b_ready) nb++;
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    compared++; if (na != 4 || nb != 4) begin mismatched++; $display("FAIL b2b_counts got a=%0d b=%0d want 4/4", na, nb); end
  endtask

  task automatic test_commit_block();
    runTo(510);
    curVc = 511; vc = 10'd511;
    a_valid = 1'b1; setA(2, 1, 1, 2, 2, 8'h55);
    #1;
    compared++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin mismatched++; $display("FAIL commit_ready got a=%b b=%b want 0/0", a_ready, b_ready); end
    cyc();
    curVc = 512; vc = 10'd512;
    #1;
    compared++; if (a_ready !== 1'b1) begin mismatched++; $display("FAIL commit_next_ready got %b want 1", a_ready); end
    cyc();
    a_valid = 1'b0;
    expCol = '0;
    for (int i = 0; i < 4; i++) begin expCol[i] = 8'h10 + 8'(i); expCol[4+i] = 8'h20 + 8'(i); end
    compared++; if (color !== expCol || frame_cnt !== 16'd1) begin mismatched++; $display("FAIL b2b_commit got color=%h cnt=%0d want %h/1", color, frame_cnt, expCol); end
    compared++; if (minX[3] !== 10'd3 || minY[7] !== 10'd3) begin mismatched++; $display("FAIL b2b_bounds got minX3=%0d minY7=%0d want 3/3", minX[3], minY[7]); end
    runTo(511);
    expCol[2] = 8'h55;
    compared++; if (color !== expCol || frame_cnt !== 16'd2) begin mismatched++; $display("FAIL commit_late_write got color=%h cnt=%0d want %h/2", color, frame_cnt, expCol); end
  endtask

  task automatic test_idx_err();
    runTo(100);
    b_valid = 1'b1; setB(12, 1, 2, 3, 4, 8'hFF);
    #1;
    compared++; if (b_ready !== 1'b1) begin mismatched++; $display("FAIL idx_err_ready got %b want 1", b_ready); end
    cyc();
    b_valid = 1'b0;
    compared++; if (idx_err !== 1'b1) begin mismatched++; $display("FAIL idx_err_pulse got %b want 1", idx_err); end
    cyc();
    compared++; if (idx_err !== 1'b0) begin mismatched++; $display("FAIL idx_err_clear got %b want 0", idx_err); end
    runTo(511);
    compared++; if (frame_cnt !== 16'd2 || color !== expCol) begin mismatched++; $display("FAIL idx_err_no_commit got cnt=%0d color=%h want 2/%h", frame_cnt, color, expCol); end
  endtask

  task automatic test_same_idx();
    runTo(100);
    a_valid = 1'b1; setA(5, 500, 400, 10, 20, 8'h1C);
    #1;
    compared++; if (a_ready !== 1'b1) begin mismatched++; $display("FAIL same_idx_a_ready got %b want 1", a_ready); end
    cyc();
    a_valid = 1'b0;
    b_valid = 1'b1; setB(5, 500, 7, 10, 3, 8'h03);
    cyc();
    b_valid = 1'b0;
    runTo(511);
    compared++; if (color[5] !== 8'h03 || frame_cnt !== 16'd3) begin mismatched++; $display("FAIL same_idx_color got %h cnt=%0d want 03/3", color[5], frame_cnt); end
    compared++; if (minX[5] !== 10'd500 || minY[5] !== 10'd7 || maxX[5] !== 10'd10 || maxY[5] !== 10'd3) begin mismatched++; $display("FAIL same_idx_bounds got %0d,%0d,%0d,%0d want 500,7,10,3", minX[5], minY[5], maxX[5], maxY[5]); end
  endtask

  task automatic test_reset_midframe();
    runTo(200);
    a_valid = 1'b1; setA(0, 1, 1, 1, 1, 8'hAA);
    cyc();
    a_valid = 1'b0;
    doReset();
    runTo(511);
    compared++; if (frame_cnt !== 16'd0 || color !== '0) begin mismatched++; $display("FAIL midreset_discard got cnt=%0d color=%h want 0/0", frame_cnt, color); end
    runTo(100);
    a_valid = 1'b1; setA(9, 0, 0, 639, 479, 8'h3F);
    cyc();
    a_valid = 1'b0;
    runTo(511);
    compared++; if (color[9] !== 8'h3F || maxX[9] !== 10'd639 || frame_cnt !== 16'd1) begin mismatched++; $display("FAIL midreset_last_idx got color=%h maxX=%0d cnt=%0d want 3f/639/1", color[9], maxX[9], frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_idle_sweep();
    test_single_write();
    test_back_to_back();
    test_commit_block();
    test_idx_err();
    test_same_idx();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/obj_table_ctrl.md
OBJ_TABLE_CTRL -- requirements
Module: obj_table_ctrl

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 10, number of rectangle entries.
REQ-002 SHALL have parameter VBP, default 31, last-line-exclusive end of vertical back porch.
REQ-003 SHALL have parameter VFP, default 511, first line of vertical front porch.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 vc  in  10  current vertical line count from the sync generator.
REQ-007 a_valid, b_valid  in  1  each requester offers a write.
REQ-008 a_ready, b_ready  out  1  write accepted this cycle when valid and ready are both high.
REQ-009 a_idx, b_idx  in  4  target entry index.
REQ-010 a_minx/a_miny/a_maxx/a_maxy, b_*  in  10 each  rectangle bounds.
REQ-011 a_color, b_color  in  8  RRRGGGBB color.
REQ-012 minX, minY, maxX, maxY  out  NUM_OBJ x 10  active table to the display compositor.
REQ-013 color  out  NUM_OBJ x 8  active table colors.
REQ-014 frame_cnt  out  16  count of vblank commits performed.
REQ-015 idx_err  out  1  one-cycle pulse when an accepted write has idx >= NUM_OBJ.

Function
REQ-016 SHALL hold a shadow table and an active table, each NUM_OBJ entries of {minx, miny, maxx, maxy, color}.
REQ-017 SHALL drive active table registers directly to the outputs; no combinational path from requester inputs to outputs.
REQ-018 vblank = (vc >= VFP) or (vc < VBP); SHALL register vblank once and generate commit on its registered 0->1 edge.
REQ-019 SHALL maintain a dirty flag: set by any accepted in-range write, cleared on commit.
REQ-020 On commit with dirty=1: copy the entire shadow table to the active table in one cycle, increment frame_cnt (wraps 0xFFFF->0).
REQ-021 On commit with dirty=0: active table and frame_cnt unchanged.
REQ-022 SHALL deassert both ready outputs during the commit cycle; otherwise at most one ready is high per cycle.
REQ-023 Arbitration: 2-way round-robin; when only one valid, grant it; when both valid, grant the one not granted last; last-granted pointer resets to B, so A wins the first tie.
REQ-024 ready SHALL be a combinational function of valids, the pointer and the commit cycle; a requester holds valid and payload until accepted.
REQ-025 Accepted write with idx < NUM_OBJ: shadow[idx] <= payload next edge; visible on outputs only after the following commit (latency = up to one frame).
REQ-026 Accepted write with idx >= NUM_OBJ: shadow unchanged, dirty unchanged, idx_err high the next cycle.
REQ-027 Two writes to the same idx before a commit: the later-accepted one wins.
REQ-028 Bounds SHALL be stored unmodified; min > max is legal (compositor draws nothing).

Reset
REQ-029 On rst_n low: shadow and active tables all zero, dirty=0, frame_cnt=0, registered vblank=1 (no spurious commit after release), pointer=B, idx_err=0, readies evaluate combinationally.
REQ-030 Reset mid-frame SHALL discard pending shadow writes; first commit occurs on the next vblank rising edge after a write.

Structure
REQ-031 Package obj_pkg SHALL hold NUM_OBJ, coordinate width (10), color width (8), VBP/VFP defaults and the entry struct typedef.
REQ-032 Arbiter SHALL be a sub-module rr_arb2 (req[1:0], block, grant[1:0], pointer update on accepted grant).

Verification
REQ-033 Reset, vc sweeps 0..524 twice with no writes -> all outputs 0, frame_cnt=0.
REQ-034 A writes idx 3 = {100,50,150,120,0xE0} at vc=200 -> outputs unchanged until vc reaches 511, then entry 3 matches and frame_cnt=1.
REQ-035 A and B valid continuously, 4 writes each -> grants alternate A,B,A,B..., no cycle with both readies high.
REQ-036 A valid on the commit cycle -> a_ready=0 that cycle, write accepted next cycle, lands in shadow, appears next frame.
REQ-037 B writes idx 12 -> idx_err pulses once, frame_cnt does not increment at next vblank.
REQ-038 A idx 5 color 0x1C then B idx 5 color 0x03 same frame -> after commit color[5]=0x03.
